branch_condition_resolver: RTL and testbench

//  Reads the four stored ALU flags (zero, negative, overflow, carry) and resolves conditional branches
//  for the i281 CPU. It computes the branch target, waits out a flag write still in flight, and issues a
//  one-cycle PC redirect/flush. It also keeps a saturating count of taken branches.

---
 rtl/branch_condition_resolver_if.sv | 56 +++++
 rtl/branch_condition_resolver.sv | 164 ++++++++++++++++
 tb/tb_branch_condition_resolver.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_condition_resolver_if.sv
// ----------------------------------------------------------------------------
// branch_condition_resolver_if
//   Bundles the decoder/PC-side branch handshake, the stored ALU flags and the
//   resolution outputs of the branch condition resolver.
//   master : decoder / front end / flag register file side (drives requests
//            and flags, observes the resolution)
//   slave  : the resolver itself
// Signals
//   Branch_Valid/Branch_Ready   branch handshake (accept = Valid & Ready)
//   Branch_Cond, Branch_Offset,
//   PC_In                       branch instruction fields
//   Flag_Write_Pending          flags are being written at the end of this cycle
//   Zero/Negative/OverFlow/
//   CarryFlagIn                 stored ALU flags
//   Clear_Count                 synchronous clear of Taken_Count
//   Resolve_Valid, Branch_Taken,
//   Redirect, PC_Target, Stall,
//   Taken_Count                 resolution results and status
// ----------------------------------------------------------------------------
interface branch_condition_resolver_if #(
    parameter int PC_WIDTH     = 5,
    parameter int OFFSET_WIDTH = 8,
    parameter int CNT_WIDTH    = 8
);
    logic                           Branch_Valid;
    logic                           Branch_Ready;
    logic [2:0]                     Branch_Cond;
    logic signed [OFFSET_WIDTH-1:0] Branch_Offset;
    logic [PC_WIDTH-1:0]            PC_In;
    logic                           Flag_Write_Pending;
    logic                           ZeroFlagIn;
    logic                           NegativeFlagIn;
    logic                           OverFlowFlagIn;
    logic                           CarryFlagIn;
    logic                           Clear_Count;
    logic                           Resolve_Valid;
    logic                           Branch_Taken;
    logic                           Redirect;
    logic [PC_WIDTH-1:0]            PC_Target;
    logic                           Stall;
    logic [CNT_WIDTH-1:0]           Taken_Count;

    modport master (
        output Branch_Valid, Branch_Cond, Branch_Offset, PC_In, Flag_Write_Pending,
               ZeroFlagIn, NegativeFlagIn, OverFlowFlagIn, CarryFlagIn, Clear_Count,
        input  Branch_Ready, Resolve_Valid, Branch_Taken, Redirect, PC_Target, Stall,
               Taken_Count
    );

    modport slave (
        input  Branch_Valid, Branch_Cond, Branch_Offset, PC_In, Flag_Write_Pending,
               ZeroFlagIn, NegativeFlagIn, OverFlowFlagIn, CarryFlagIn, Clear_Count,
        output Branch_Ready, Resolve_Valid, Branch_Taken, Redirect, PC_Target, Stall,
               Taken_Count
    );
endinterface

// File: rtl/branch_condition_resolver.sv
// ----------------------------------------------------------------------------
// branch_condition_resolver
//   Resolves i281 conditional branches against the stored ALU flags. The target
//   PC_In + 1 + sext(offset) is computed at accept. If the flag register is
//   being written in the accept cycle, the branch is parked in WAIT (Stall=1)
//   until the write settles, then evaluated with the fresh flags. A resolution
//   is presented for exactly one cycle (Resolve_Valid, Redirect when taken).
//   A saturating counter tracks taken branches.
// Ports
//   Clock  : rising-edge clock
//   Reset  : asynchronous, active-low reset
//   bus    : slave side of branch_condition_resolver_if (handshake, flags,
//            resolution outputs)
// ----------------------------------------------------------------------------
module branch_condition_resolver #(
    parameter int PC_WIDTH     = 5,
    parameter int OFFSET_WIDTH = 8,
    parameter int CNT_WIDTH    = 8
) (
    input logic                     Clock,
    input logic                     Reset,
    branch_condition_resolver_if.slave bus
);

    localparam int SUM_W = (PC_WIDTH > OFFSET_WIDTH) ? PC_WIDTH : OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        RESOLVED = 2'd2
    } stateT;

    stateT               state;
    stateT               nextState;
    logic [2:0]          condReg;
    logic [PC_WIDTH-1:0] targetLatch;
    logic [PC_WIDTH-1:0] targetReg;
    logic                takenReg;
    logic [CNT_WIDTH-1:0] countReg;

    logic                accept;
    logic                resolveNow;
    logic                outcome;
    logic [PC_WIDTH-1:0] acceptTarget;
    logic [PC_WIDTH-1:0] resolveTarget;

    // Signed-compare conditions follow the flags of the last flag-setting op:
    // "greater or equal" holds when N and V agree.
    function automatic logic evalCond(input logic [2:0] cond, input logic z, input logic n,
                                      input logic v, input logic c);
        logic ge;
        logic result;
        ge = ~(n ^ v);
        case (cond)
            3'b000:  result = 1'b0;
            3'b001:  result = 1'b1;
            3'b010:  result = z;
            3'b011:  result = ~z;
            3'b100:  result = ge & ~z;
            3'b101:  result = ge;
            3'b110:  result = c;
            default: result = ~c;
        endcase
        return result;
    endfunction

    // Target arithmetic is modulo 2^PC_WIDTH; the offset is sign-extended to
    // the working width first so negative offsets wrap correctly.
    function automatic logic [PC_WIDTH-1:0] calcTarget(input logic [PC_WIDTH-1:0] pc,
                                                       input logic signed [OFFSET_WIDTH-1:0] off);
        logic signed [SUM_W-1:0] offExt;
        logic [SUM_W-1:0]        sum;
        offExt = SUM_W'(off);
        sum    = SUM_W'(pc) + SUM_W'(1) + offExt;
        return sum[PC_WIDTH-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    endfunction

    assign accept       = bus.Branch_Valid & (state == IDLE);
    assign acceptTarget = calcTarget(bus.PC_In, bus.Branch_Offset);

    always_comb begin
        nextState     = state;
        resolveNow    = 1'b0;
        outcome       = 1'b0;
        resolveTarget = targetLatch;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.Flag_Write_Pending) begin
                        nextState = WAIT;
                    end else begin
                        nextState     = RESOLVED;
                        resolveNow    = 1'b1;
                        resolveTarget = acceptTarget;
                        outcome       = evalCond(bus.Branch_Cond, bus.ZeroFlagIn, bus.NegativeFlagIn,
                                                 bus.OverFlowFlagIn, bus.CarryFlagIn);
                    end
                end
            end
            WAIT: begin
                if (!bus.Flag_Write_Pending) begin
                    nextState  = RESOLVED;
                    resolveNow = 1'b1;
                    outcome    = evalCond(condReg, bus.ZeroFlagIn, bus.NegativeFlagIn,
                                          bus.OverFlowFlagIn, bus.CarryFlagIn);
                end
            end
            RESOLVED: nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The latched condition/target carry a branch through WAIT; the visible
    // outcome and target only change when a resolution is issued.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            condReg     <= 3'b000;
            targetLatch <= '0;
            targetReg   <= '0;
            takenReg    <= 1'b0;
        end else begin
            if (accept) begin
                condReg     <= bus.Branch_Cond;
                targetLatch <= acceptTarget;
            end
            if (resolveNow) begin
                takenReg  <= outcome;
                targetReg <= resolveTarget;
            end
        end
    end

    // Clear has priority over an increment landing in the same cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            countReg <= '0;
        end else if (bus.Clear_Count) begin
            countReg <= '0;
        end else if ((state == RESOLVED) && takenReg) begin
            countReg <= satInc(countReg);
        end
    end

    assign bus.Branch_Ready  = (state == IDLE);
    assign bus.Resolve_Valid = (state == RESOLVED);
    assign bus.Stall         = (state == WAIT);
    assign bus.Redirect      = (state == RESOLVED) & takenReg;
    assign bus.Branch_Taken  = takenReg;
    assign bus.PC_Target     = targetReg;
    assign bus.Taken_Count   = countReg;

endmodule

// File: tb/tb_branch_condition_resolver.sv
// ----------------------------------------------------------------------------
// tb_branch_condition_resolver
//   Scoreboarded bench for branch_condition_resolver. Expected outcomes and
//   targets are pushed when a branch is driven and popped when the resolver
//   presents Resolve_Valid. A narrow counter makes saturation reachable.
// ----------------------------------------------------------------------------
module tb_branch_condition_resolver;

    localparam int PC_WIDTH     = 5;
    localparam int OFFSET_WIDTH = 8;
    localparam int CNT_WIDTH    = 2;
    localparam int MAXCNT       = (1 << CNT_WIDTH) - 1;

    typedef struct {
        logic                taken;
        logic [PC_WIDTH-1:0] target;
    } expT;

    typedef struct {
        logic [2:0] cond;
        logic [3:0] fl;    // {Z, N, V, C}
        int         pc;
        int         off;
    } rowT;

    logic Clock;
    logic Reset;
    int   nCmp = 0;
    int   nFail = 0;
    int   mc = 0;
    expT  sb[$];

    rowT condRows[13] = '{
        '{3'b010, 4'b1000,  4,   3},
        '{3'b100, 4'b0110,  6,  -2},
        '{3'b101, 4'b0100,  9,   5},
        '{3'b100, 4'b1110,  2,   1},
        '{3'b101, 4'b0000, 17,  -4},
        '{3'b000, 4'b1111,  3,   7},
        '{3'b001, 4'b0000, 20,   0},
        '{3'b011, 4'b0000,  5,  10},
        '{3'b011, 4'b1000,  1,   1},
        '{3'b110, 4'b0001, 11, -11},
        '{3'b111, 4'b0001, 13,   2},
        '{3'b111, 4'b0000, 30,   6},
        '{3'b101, 4'b0011,  8,   8}
    };

    rowT wrapRows[4] = '{
        '{3'b001, 4'b0000, 31,    0},
        '{3'b001, 4'b0000,  0,   -1},
        '{3'b000, 4'b0000, 10, -128},
        '{3'b001, 4'b0000, 20,  127}
    };

    branch_condition_resolver_if #(
        .PC_WIDTH(PC_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    branch_condition_resolver #(
        .PC_WIDTH(PC_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic modelTaken(input logic [2:0] cond, input logic [3:0] fl);
        logic z, n, v, c;
        {z, n, v, c} = fl;
        case (cond)
            3'd0:    return 1'b0;
            3'd1:    return 1'b1;
            3'd2:    return z;
            3'd3:    return !z;
            3'd4:    return (n == v) && !z;
            3'd5:    return (n == v);
            3'd6:    return c;
            default: return !c;
        endcase
    endfunction

    function automatic logic [PC_WIDTH-1:0] modelTarget(input int pc, input int off);
        int m;
        int t;
        m = 1 << PC_WIDTH;
        t = (pc + 1 + off) % m;
        if (t < 0) t += m;
        return PC_WIDTH'(t);
    endfunction

    function automatic int modelCount(input int cnt, input logic taken, input logic clr);
        if (clr) return 0;
        if (taken) return (cnt == MAXCNT) ? MAXCNT : cnt + 1;
        return cnt;
    endfunction

    // Drives one branch for a single accept cycle; expFl are the flags the
    // resolution is expected to use.
    task automatic driveBranch(input logic [2:0] cond, input int pc, input int off,
                               input logic [3:0] fl, input logic pend, input logic [3:0] expFl);
        expT e;
        e.taken  = modelTaken(cond, expFl);
        e.target = modelTarget(pc, off);
        sb.push_back(e);
        bus.Branch_Cond        = cond;
        bus.PC_In              = PC_WIDTH'(pc);
        bus.Branch_Offset      = OFFSET_WIDTH'(off);
        {bus.ZeroFlagIn, bus.NegativeFlagIn, bus.OverFlowFlagIn, bus.CarryFlagIn} = fl;
        bus.Flag_Write_Pending = pend;
        bus.Branch_Valid       = 1'b1;
        @(negedge Clock);
        bus.Branch_Valid       = 1'b0;
    endtask

    // Waits (bounded) for Resolve_Valid; returns at the negedge where it is seen.
    task automatic waitResolve(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            if (bus.Resolve_Valid === 1'b1) got = 1'b1;
            else begin
                @(negedge Clock);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        nCmp++; if (bus.Branch_Ready !== 1'b1) begin nFail++; $display("FAIL reset Ready: got %b want 1", bus.Branch_Ready); end
        nCmp++; if (bus.Resolve_Valid !== 1'b0) begin nFail++; $display("FAIL reset Resolve_Valid: got %b want 0", bus.Resolve_Valid); end
        nCmp++; if (bus.Stall !== 1'b0) begin nFail++; $display("FAIL reset Stall: got %b want 0", bus.Stall); end
        nCmp++; if (bus.Redirect !== 1'b0) begin nFail++; $display("FAIL reset Redirect: got %b want 0", bus.Redirect); end
        nCmp++; if (bus.Branch_Taken !== 1'b0) begin nFail++; $display("FAIL reset Taken: got %b want 0", bus.Branch_Taken); end
        nCmp++; if (bus.PC_Target !== '0) begin nFail++; $display("FAIL reset PC_Target: got %0d want 0", bus.PC_Target); end
        nCmp++; if (bus.Taken_Count !== '0) begin nFail++; $display("FAIL reset Count: got %0d want 0", bus.Taken_Count); end
        Reset = 1'b1;
        @(negedge Clock);
        nCmp++; if (bus.Branch_Ready !== 1'b1 || bus.Resolve_Valid !== 1'b0) begin
            nFail++; $display("FAIL post-reset idle: got Ready=%b RV=%b want Ready=1 RV=0", bus.Branch_Ready, bus.Resolve_Valid);
        end
        mc = 0;
    endtask

    task automatic test_conditions();
        bit  got;
        int  lat;
        expT e;
        for (int i = 0; i < 13; i++) begin
            driveBranch(condRows[i].cond, condRows[i].pc, condRows[i].off, condRows[i].fl, 1'b0, condRows[i].fl);
            waitResolve(got, lat);
            nCmp++;
            if (!got || lat != 0) begin
                nFail++; $display("FAIL cond[%0d] latency: got seen=%0b extra=%0d want seen=1 extra=0", i, got, lat);
            end
            if (!got) begin
                sb.delete();
                continue;
            end
            e = sb.pop_front();
            nCmp++; if (bus.Branch_Taken !== e.taken) begin nFail++; $display("FAIL cond[%0d] taken: got %b want %b", i, bus.Branch_Taken, e.taken); end
            nCmp++; if (bus.Redirect !== e.taken) begin nFail++; $display("FAIL cond[%0d] redirect: got %b want %b", i, bus.Redirect, e.taken); end
            nCmp++; if (bus.PC_Target !== e.target) begin nFail++; $display("FAIL cond[%0d] target: got %0d want %0d", i, bus.PC_Target, e.target); end
            mc = modelCount(mc, e.taken, 1'b0);
            @(negedge Clock);
            nCmp++; if (bus.Resolve_Valid !== 1'b0 || bus.Redirect !== 1'b0) begin
                nFail++; $display("FAIL cond[%0d] pulse: got RV=%b Redirect=%b want 0 0", i, bus.Resolve_Valid, bus.Redirect);
            end
            nCmp++; if (bus.Taken_Count !== CNT_WIDTH'(mc)) begin nFail++; $display("FAIL cond[%0d] count: got %0d want %0d", i, bus.Taken_Count, mc); end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        driveBranch(3'b001, 7, 1, 4'b0000, 1'b1, 4'b0000);
        nCmp++; if (bus.Stall !== 1'b1) begin nFail++; $display("FAIL midwait stall: got %b want 1", bus.Stall); end
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        bus.Flag_Write_Pending = 1'b0;
        sb.delete();
        mc = 0;
        nCmp++; if (bus.Branch_Ready !== 1'b1 || bus.Stall !== 1'b0) begin
            nFail++; $display("FAIL midwait idle: got Ready=%b Stall=%b want 1 0", bus.Branch_Ready, bus.Stall);
        end
        nCmp++; if (bus.Taken_Count !== '0) begin nFail++; $display("FAIL midwait count: got %0d want 0", bus.Taken_Count); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.Resolve_Valid !== 1'b0) seen = 1'b1;
            @(negedge Clock);
        end
        nCmp++; if (seen) begin nFail++; $display("FAIL midwait discard: got Resolve_Valid=1 want none"); end
    endtask

    task automatic test_hazard();
        bit  got;
        int  lat;
        expT e;
        driveBranch(3'b110, 12, -5, 4'b0000, 1'b1, 4'b0001);
        nCmp++; if (bus.Stall !== 1'b1 || bus.Branch_Ready !== 1'b0) begin
            nFail++; $display("FAIL hazard wait1: got Stall=%b Ready=%b want 1 0", bus.Stall, bus.Branch_Ready);
        end
        // A request presented while not ready must be ignored.
        bus.Branch_Cond  = 3'b001;
        bus.PC_In        = '0;
        bus.Branch_Valid = 1'b1;
        @(negedge Clock);
        nCmp++; if (bus.Stall !== 1'b1) begin nFail++; $display("FAIL hazard wait2: got Stall=%b want 1", bus.Stall); end
        bus.Branch_Valid       = 1'b0;
        bus.Flag_Write_Pending = 1'b0;
        bus.CarryFlagIn        = 1'b1;
        waitResolve(got, lat);
        nCmp++;
        if (!got || lat != 1) begin
            nFail++; $display("FAIL hazard latency: got seen=%0b extra=%0d want seen=1 extra=1", got, lat);
        end
        if (!got) begin
            sb.delete();
            return;
        end
        e = sb.pop_front();
        nCmp++; if (bus.Branch_Taken !== e.taken) begin nFail++; $display("FAIL hazard taken: got %b want %b", bus.Branch_Taken, e.taken); end
        nCmp++; if (bus.Redirect !== e.taken) begin nFail++; $display("FAIL hazard redirect: got %b want %b", bus.Redirect, e.taken); end
        nCmp++; if (bus.PC_Target !== e.target) begin nFail++; $display("FAIL hazard target: got %0d want %0d", bus.PC_Target, e.target); end
        nCmp++; if (bus.Stall !== 1'b0) begin nFail++; $display("FAIL hazard stall-drop: got %b want 0", bus.Stall); end
        mc = modelCount(mc, e.taken, 1'b0);
        @(negedge Clock);
        nCmp++; if (bus.Resolve_Valid !== 1'b0 || bus.Branch_Ready !== 1'b1) begin
            nFail++; $display("FAIL hazard idle: got RV=%b Ready=%b want 0 1", bus.Resolve_Valid, bus.Branch_Ready);
        end
        nCmp++; if (bus.Taken_Count !== CNT_WIDTH'(mc)) begin nFail++; $display("FAIL hazard count: got %0d want %0d", bus.Taken_Count, mc); end
        bus.CarryFlagIn = 1'b0;
    endtask

    task automatic test_wrap();
        bit  got;
        int  lat;
        expT e;
        for (int i = 0; i < 4; i++) begin
            driveBranch(wrapRows[i].cond, wrapRows[i].pc, wrapRows[i].off, wrapRows[i].fl, 1'b0, wrapRows[i].fl);
            waitResolve(got, lat);
            nCmp++;
            if (!got) begin
                nFail++; $display("FAIL wrap[%0d] resolve: got none want Resolve_Valid=1", i);
                sb.delete();
                continue;
            end
            e = sb.pop_front();
            nCmp++; if (bus.PC_Target !== e.target) begin nFail++; $display("FAIL wrap[%0d] target: got %0d want %0d", i, bus.PC_Target, e.target); end
            nCmp++; if (bus.Redirect !== e.taken) begin nFail++; $display("FAIL wrap[%0d] redirect: got %b want %b", i, bus.Redirect, e.taken); end
            mc = modelCount(mc, e.taken, 1'b0);
            @(negedge Clock);
            nCmp++; if (bus.Taken_Count !== CNT_WIDTH'(mc)) begin nFail++; $display("FAIL wrap[%0d] count: got %0d want %0d", i, bus.Taken_Count, mc); end
        end
    endtask

    task automatic test_back_to_back();
        expT e;
        expT a;
        // Branch A, then branch B held on Valid straight through A's RESOLVED cycle.
        driveBranch(3'b001, 1, 1, 4'b0000, 1'b0, 4'b0000);
        a = sb.pop_front();
        nCmp++; if (bus.Resolve_Valid !== 1'b1 || bus.Branch_Ready !== 1'b0) begin
            nFail++; $display("FAIL b2b A resolve: got RV=%b Ready=%b want 1 0", bus.Resolve_Valid, bus.Branch_Ready);
        end
        nCmp++; if (bus.PC_Target !== a.target || bus.Branch_Taken !== a.taken) begin
            nFail++; $display("FAIL b2b A result: got tgt=%0d tk=%b want tgt=%0d tk=%b", bus.PC_Target, bus.Branch_Taken, a.target, a.taken);
        end
        mc = modelCount(mc, a.taken, 1'b0);
        e.taken  = modelTaken(3'b000, 4'b0000);
        e.target = modelTarget(5, 2);
        sb.push_back(e);
        bus.Branch_Cond   = 3'b000;
        bus.PC_In         = PC_WIDTH'(5);
        bus.Branch_Offset = OFFSET_WIDTH'(2);
        bus.Branch_Valid  = 1'b1;
        @(negedge Clock);
        nCmp++; if (bus.Resolve_Valid !== 1'b0 || bus.Branch_Ready !== 1'b1) begin
            nFail++; $display("FAIL b2b gap: got RV=%b Ready=%b want 0 1", bus.Resolve_Valid, bus.Branch_Ready);
        end
        nCmp++; if (bus.PC_Target !== a.target) begin nFail++; $display("FAIL b2b held target: got %0d want %0d", bus.PC_Target, a.target); end
        nCmp++; if (bus.Taken_Count !== CNT_WIDTH'(mc)) begin nFail++; $display("FAIL b2b A count: got %0d want %0d", bus.Taken_Count, mc); end
        @(negedge Clock);
        bus.Branch_Valid = 1'b0;
        e = sb.pop_front();
        nCmp++; if (bus.Resolve_Valid !== 1'b1) begin nFail++; $display("FAIL b2b B resolve: got RV=%b want 1", bus.Resolve_Valid); end
        nCmp++; if (bus.PC_Target !== e.target || bus.Redirect !== e.taken) begin
            nFail++; $display("FAIL b2b B result: got tgt=%0d rd=%b want tgt=%0d rd=%b", bus.PC_Target, bus.Redirect, e.target, e.taken);
        end
        mc = modelCount(mc, e.taken, 1'b0);
        @(negedge Clock);
        nCmp++; if (bus.Taken_Count !== CNT_WIDTH'(mc)) begin nFail++; $display("FAIL b2b B count: got %0d want %0d", bus.Taken_Count, mc); end
    endtask

    task automatic test_saturation();
        bit   got;
        int   lat;
        logic clr;
        expT  e;
        bus.Clear_Count = 1'b1;
        @(negedge Clock);
        bus.Clear_Count = 1'b0;
        mc = 0;
        nCmp++; if (bus.Taken_Count !== '0) begin nFail++; $display("FAIL sat clear: got %0d want 0", bus.Taken_Count); end
        for (int i = 0; i < 6; i++) begin
            clr = (i == 5);
            driveBranch(3'b001, i, i, 4'b0000, 1'b0, 4'b0000);
            waitResolve(got, lat);
            nCmp++;
            if (!got) begin
                nFail++; $display("FAIL sat[%0d] resolve: got none want Resolve_Valid=1", i);
                sb.delete();
                continue;
            end
            e = sb.pop_front();
            nCmp++; if (bus.Branch_Taken !== e.taken) begin nFail++; $display("FAIL sat[%0d] taken: got %b want %b", i, bus.Branch_Taken, e.taken); end
            bus.Clear_Count = clr;
            mc = modelCount(mc, e.taken, clr);
            @(negedge Clock);
            bus.Clear_Count = 1'b0;
            nCmp++; if (bus.Taken_Count !== CNT_WIDTH'(mc)) begin nFail++; $display("FAIL sat[%0d] count: got %0d want %0d", i, bus.Taken_Count, mc); end
        end
    endtask

    initial begin
        Reset                  = 1'b0;
        bus.Branch_Valid       = 1'b0;
        bus.Branch_Cond        = 3'b000;
        bus.Branch_Offset      = '0;
        bus.PC_In              = '0;
        bus.Flag_Write_Pending = 1'b0;
        bus.ZeroFlagIn         = 1'b0;
        bus.NegativeFlagIn     = 1'b0;
        bus.OverFlowFlagIn     = 1'b0;
        bus.CarryFlagIn        = 1'b0;
        bus.Clear_Count        = 1'b0;
        repeat (3) @(negedge Clock);

        test_reset();
        test_conditions();
        test_reset_mid_wait();
        test_hazard();
        test_wrap();
        test_back_to_back();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
